// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types for the pwm block and its duty-cycle fader.
//   DUTY_W        : width of a duty value
//   duty_t        : duty value type, shared by pwm and pwm_fader
//   fader_state_t : fader FSM states
//   fader_dir_t   : breathing direction
//   step_toward() : move a duty value toward a goal by at most 'step',
//                   never overshooting the goal
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int DUTY_W = 8;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP    = 2'd1,
      BREATHE = 2'd2
   } fader_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } fader_dir_t;

   // The 9-bit difference keeps the sign; the step is clipped to the
   // remaining distance so the result lands exactly on the goal.
   function automatic duty_t step_toward(input duty_t cur, input duty_t goal,
                                         input duty_t step);
      logic [DUTY_W:0] diff;
      duty_t           mag;
      duty_t           amt;
      diff = {1'b0, goal} - {1'b0, cur};
      mag  = diff[DUTY_W] ? -diff[DUTY_W-1:0] : diff[DUTY_W-1:0];
      amt  = (mag < step) ? mag : step;
      return diff[DUTY_W] ? (cur - amt) : (cur + amt);
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Free-running prescaler: counts 0..TICK_DIV-1 while enabled and pulses
// 'tick' during the last count. Also usable as the pwm prescaler.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable; when low the count is frozen and no tick is issued
//   clr  : synchronous restart of the count at 0 (wins over en)
//   tick : one-cycle pulse on the final count of each period
// -----------------------------------------------------------------------------
module pwm_tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == CNT_MAX) ? '0 : count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick = en && (count_q == CNT_MAX);

endmodule

// File: rtl/pwm_fader.sv
// -----------------------------------------------------------------------------
// pwm_fader
// Ramps duty_cycle toward a programmed target, one step every TICK_DIV
// clocks, optionally breathing (triangle between 0 and the target).
//   clk          : system clock
//   rst          : synchronous active-high reset
//   target       : requested duty value
//   target_valid : one-cycle strobe, latches target and restarts the tick
//   breathe      : level, 1 = triangle between 0 and target once reached
//   hold         : level, freezes tick counter and duty
//   duty_cycle   : current duty (to pwm.duty_cycle)
//   duty_valid   : one-cycle pulse in the first cycle a new duty is visible
//   busy         : high while the FSM is not IDLE
//   done         : one-cycle pulse when a non-breathing ramp completes
// Handshake: duty_valid is a qualifier only; the consumer has no ready and
// must take duty_cycle in the cycle duty_valid is high.
// -----------------------------------------------------------------------------
module pwm_fader
   import pwm_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int STEP     = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  duty_t target,
   input  logic  target_valid,
   input  logic  breathe,
   input  logic  hold,
   output duty_t duty_cycle,
   output logic  duty_valid,
   output logic  busy,
   output logic  done
);

   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("pwm_fader: TICK_DIV must be >= 2");
   end
   if (STEP < 1 || STEP > 255) begin : g_bad_step
      $error("pwm_fader: STEP must be in 1..255");
   end

   localparam duty_t STEP_V = duty_t'(STEP);

   fader_state_t state_q, state_d;
   fader_dir_t   dir_q, dir_d;
   duty_t        target_q, target_d;
   duty_t        duty_q, duty_d;
   logic         valid_q, valid_d;
   logic         done_q, done_d;

   logic         tick;
   duty_t        goal;
   duty_t        stepped;

   pwm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   ((state_q != IDLE) && !hold),
      .clr  (target_valid || (state_q == IDLE)),
      .tick (tick)
   );

   // While breathing downward the goal is 0; everywhere else it is the target.
   assign goal    = (state_q == BREATHE && dir_q == DIR_DOWN) ? '0 : target_q;
   assign stepped = step_toward(duty_q, goal, STEP_V);

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      target_d = target_q;
      duty_d   = duty_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;

      if (target_valid) begin
         // A new target always wins over a coincident tick.
         target_d = target;
         if (target != duty_q) begin
            state_d = RAMP;
         end else if (breathe && target != '0) begin
            state_d = BREATHE;
            dir_d   = DIR_DOWN;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end else begin
         case (state_q)
            RAMP: begin
               if (tick) begin
                  duty_d  = stepped;
                  valid_d = (stepped != duty_q);
                  if (stepped == target_q) begin
                     if (breathe && target_q != '0) begin
                        state_d = BREATHE;
                        dir_d   = DIR_DOWN;
                     end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            BREATHE: begin
               if (!breathe) begin
                  state_d = RAMP;
               end else if (tick) begin
                  duty_d  = stepped;
                  valid_d = (stepped != duty_q);
                  // Flip on arrival; the new direction is used on the next
                  // tick, so each endpoint is held for one tick period.
                  if (stepped == goal) begin
                     dir_d = (dir_q == DIR_DOWN) ? DIR_UP : DIR_DOWN;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         dir_q    <= DIR_UP;
         target_q <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         target_q <= target_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   assign duty_cycle = duty_q;
   // Strobes are masked while reset is asserted so none leak out in the
   // cycle before the reset edge.
   assign duty_valid = valid_q && !rst;
   assign done       = done_q && !rst;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_pwm_fader
// Bench for pwm_fader. Main instance: TICK_DIV=4, STEP=16. Second instance
// (TICK_DIV=2, STEP=255) covers saturation at the top of the range.
// Each expected output event is {cycle, duty_valid, done, duty} and is pushed
// when the stimulus is driven; monitors pop and compare on every event.
// -----------------------------------------------------------------------------
module tb_pwm_fader;

   localparam int EW = 26;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;

   logic [7:0] target;
   logic       target_valid, breathe, hold;
   logic [7:0] duty_cycle;
   logic       duty_valid, busy, done;

   logic [7:0] s_target;
   logic       s_tv, s_breathe, s_hold;
   logic [7:0] s_duty;
   logic       s_valid, s_busy, s_done;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] sat_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pwm_fader #(.TICK_DIV(4), .STEP(16)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .target       (target),
      .target_valid (target_valid),
      .breathe      (breathe),
      .hold         (hold),
      .duty_cycle   (duty_cycle),
      .duty_valid   (duty_valid),
      .busy         (busy),
      .done         (done)
   );

   pwm_fader #(.TICK_DIV(2), .STEP(255)) u_sat (
      .clk          (clk),
      .rst          (rst),
      .target       (s_target),
      .target_valid (s_tv),
      .breathe      (s_breathe),
      .hold         (s_hold),
      .duty_cycle   (s_duty),
      .duty_valid   (s_valid),
      .busy         (s_busy),
      .done         (s_done)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [EW-1:0] mk(input int c, input bit v, input bit dn,
                                        input int d);
      return {c[15:0], v, dn, d[7:0]};
   endfunction

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (duty_valid || done) begin
         if (exp_q.size() == 0)
            check_eq("unexpected_evt", {cyc[15:0], duty_valid, done, duty_cycle}, '0);
         else
            check_eq("evt", {cyc[15:0], duty_valid, done, duty_cycle}, exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (s_valid || s_done) begin
         if (sat_q.size() == 0)
            check_eq("sat_unexpected_evt", {cyc[15:0], s_valid, s_done, s_duty}, '0);
         else
            check_eq("sat_evt", {cyc[15:0], s_valid, s_done, s_duty}, sat_q.pop_front());
      end
   end

   // ---------------- model / driver tasks ----------------
   // Expected events of a plain ramp from 'start' to 'tgt' accepted so that
   // cycle 'a' is the first cycle after the accepting edge.
   task automatic push_ramp(input int start, input int tgt, input int a,
                            input int step, input int div, input bit sat);
      int d;
      int n;
      int mag;
      logic [EW-1:0] e;
      d = start;
      n = 0;
      if (d == tgt) begin
         e = mk(a, 1'b0, 1'b1, d);
         if (sat) sat_q.push_back(e); else exp_q.push_back(e);
      end
      while (d != tgt) begin
         mag = (tgt > d) ? tgt - d : d - tgt;
         if (mag > step) mag = step;
         d = (tgt > d) ? d + mag : d - mag;
         n++;
         e = mk(a + n * div, 1'b1, d == tgt, d);
         if (sat) sat_q.push_back(e); else exp_q.push_back(e);
      end
   endtask

   task automatic send_target(input int t, output int a);
      @(posedge clk); #1;
      target       = t[7:0];
      target_valid = 1'b1;
      a            = cyc + 1;
      @(posedge clk); #1;
      target_valid = 1'b0;
   endtask

   task automatic send_sat(input int t, output int a);
      @(posedge clk); #1;
      s_target = t[7:0];
      s_tv     = 1'b1;
      a        = cyc + 1;
      @(posedge clk); #1;
      s_tv     = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input bit sat, input int budget);
      int k;
      k = 0;
      while (((sat ? sat_q.size() : exp_q.size()) != 0) && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check_eq(tag, sat ? sat_q.size() : exp_q.size(), 0);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int a;
      int a2;
      int cnt;
      int k;
      int bv[13] = '{16, 32, 48, 32, 16, 0, 16, 32, 48, 32, 16, 32, 48};

      rst = 1'b1;
      target = '0; target_valid = 1'b0; breathe = 1'b0; hold = 1'b0;
      s_target = '0; s_tv = 1'b0; s_breathe = 1'b0; s_hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_duty", duty_cycle, 0);
      check_eq("rst_valid", duty_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ramp up 0 -> 42
      send_target(42, a);
      push_ramp(0, 42, a, 16, 4, 1'b0);
      @(negedge clk);
      check_eq("busy_ramp_up", busy, 1);
      wait_drain("drain_ramp_up", 1'b0, 40);
      @(negedge clk);
      check_eq("busy_after_up", busy, 0);

      // ramp down 42 -> 0
      send_target(0, a);
      push_ramp(42, 0, a, 16, 4, 1'b0);
      wait_drain("drain_ramp_down", 1'b0, 40);
      @(negedge clk);
      check_eq("busy_after_down", busy, 0);

      // no-op target: done one cycle later, no duty_valid
      send_target(0, a);
      push_ramp(0, 0, a, 16, 4, 1'b0);
      wait_drain("drain_noop", 1'b0, 20);

      // reset mid-ramp at duty=32
      send_target(42, a);
      push_ramp(0, 42, a, 16, 4, 1'b0);
      k = 0;
      while (exp_q.size() > 1 && k < 40) begin
         @(negedge clk); #1;
         k++;
      end
      check_eq("reach_32", duty_cycle, 32);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check_eq("midrst_duty", duty_cycle, 0);
      check_eq("midrst_valid", duty_valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (duty_valid || done) cnt++;
      end
      check_eq("quiet_after_rst", cnt, 0);

      // breathe 0 -> 48 triangle, drop breathe at the second descending 16
      breathe = 1'b1;
      send_target(48, a);
      for (int i = 0; i < 13; i++)
         exp_q.push_back(mk(a + 4 * (i + 1), 1'b1, i == 12, bv[i]));
      wait_cyc(a + 44);
      breathe = 1'b0;
      wait_drain("drain_breathe", 1'b0, 40);
      @(negedge clk);
      check_eq("busy_after_breathe", busy, 0);

      // hold for 10 cycles mid-ramp 48 -> 0
      send_target(0, a);
      exp_q.push_back(mk(a + 4, 1'b1, 1'b0, 32));
      exp_q.push_back(mk(a + 18, 1'b1, 1'b0, 16));
      exp_q.push_back(mk(a + 22, 1'b1, 1'b1, 0));
      wait_cyc(a + 5);
      hold = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
      end
      hold = 1'b0;
      wait_drain("drain_hold", 1'b0, 40);

      // target_valid coincident with a tick: no step, counter restarts
      send_target(40, a);
      exp_q.push_back(mk(a + 4, 1'b1, 1'b0, 16));
      wait_cyc(a + 7);
      target       = 8'd50;
      target_valid = 1'b1;
      a2           = cyc + 1;
      @(posedge clk); #1;
      target_valid = 1'b0;
      push_ramp(16, 50, a2, 16, 4, 1'b0);
      wait_drain("drain_collide", 1'b0, 40);

      // saturation on the STEP=255 / TICK_DIV=2 instance
      send_sat(200, a);
      push_ramp(0, 200, a, 255, 2, 1'b1);
      wait_drain("drain_sat_200", 1'b1, 20);
      send_sat(255, a);
      push_ramp(200, 255, a, 255, 2, 1'b1);
      wait_drain("drain_sat_255", 1'b1, 20);
      repeat (4) @(negedge clk);
      check_eq("sat_final_duty", s_duty, 255);
      check_eq("sat_final_busy", s_busy, 0);

      check_eq("final_exp_q", exp_q.size(), 0);
      check_eq("final_sat_q", sat_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
